// File: rtl/trng_pkg.sv
// Shared TRNG types and constants: reader FSM states and UART framing levels.
package trng_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam int   DATA_BITS = 8;
   localparam logic TX_IDLE   = 1'b1;
   localparam logic TX_START  = 1'b0;
   localparam logic TX_STOP   = 1'b1;

endpackage : trng_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and pulses bit_done on the last count of each bit.
module uart_baud_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_done
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign bit_done = (cnt == CNT_W'(CLK_DIV - 1));

   // NOTE: reset is tested inside the clocked block, so it is synchronous; no async sensitivity.
   always_ff @(posedge clk) begin
      if (rst || restart || bit_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule : uart_baud_gen

// File: rtl/entropy_uart_reader.sv
// Pulls bytes from the entropy buffer over req/vector_valid and sends each as an 8N1 UART frame.
// Define ENTROPY_UART_PARITY_EN to insert an even-parity bit between data and stop.
module entropy_uart_reader
   import trng_pkg::*;
#(
   parameter int CLK_DIV     = 16,
   parameter int REQ_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] vector,
   input  logic       vector_valid,
   output logic       req,
   output logic       tx,
   output logic       busy,
   output logic       stall
);

   localparam int WAIT_W = $clog2(REQ_TIMEOUT + 1);
   localparam int IDX_W  = $clog2(DATA_BITS);

   state_e                 state;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [DATA_BITS-1:0]   shift;
   logic [IDX_W-1:0]       bit_idx;
   logic                   bit_done;
   logic                   baud_restart;
`ifdef ENTROPY_UART_PARITY_EN
   logic                   parity_bit;
`endif

   // Holding the timer at zero outside the serial states makes every serial state start at count 0.
   assign baud_restart = (state == IDLE) || (state == REQ);
   assign busy         = (state != IDLE);

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .restart  (baud_restart),
      .bit_done (bit_done)
   );

   // NOTE: all state and outputs update with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req      <= 1'b0;
         tx       <= TX_IDLE;
         stall    <= 1'b0;
         wait_cnt <= '0;
         shift    <= '0;
         bit_idx  <= '0;
`ifdef ENTROPY_UART_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx <= TX_IDLE;
               if (enable) begin
                  state    <= REQ;
                  req      <= 1'b1;
                  wait_cnt <= '0;
               end
            end

            REQ: begin
               if (req && vector_valid) begin
                  shift   <= vector;
                  req     <= 1'b0;
                  stall   <= 1'b0;
                  bit_idx <= '0;
                  tx      <= TX_START;
                  state   <= START;
`ifdef ENTROPY_UART_PARITY_EN
                  parity_bit <= ^vector;
`endif
               end else if (!enable) begin
                  req   <= 1'b0;
                  state <= IDLE;
               end else if (wait_cnt != WAIT_W'(REQ_TIMEOUT)) begin
                  // Saturating wait counter; stall rises on the cycle it reaches the limit.
                  wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == WAIT_W'(REQ_TIMEOUT - 1)) begin
                     stall <= 1'b1;
                  end
               end
            end

            START: begin
               if (bit_done) begin
                  tx      <= shift[0];
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end

            DATA: begin
               if (bit_done) begin
                  shift <= shift >> 1;
                  if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef ENTROPY_UART_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= TX_STOP;
                     state <= STOP;
`endif
                  end else begin
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end

`ifdef ENTROPY_UART_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  tx    <= TX_STOP;
                  state <= STOP;
               end
            end
`endif

            STOP: begin
               if (bit_done) begin
                  tx <= TX_IDLE;
                  if (enable) begin
                     state    <= REQ;
                     req      <= 1'b1;
                     wait_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            default: begin
               state <= IDLE;
               req   <= 1'b0;
               tx    <= TX_IDLE;
            end
         endcase
      end
   end

endmodule : entropy_uart_reader

// File: tb/tb_entropy_uart_reader.sv
// Scoreboard bench: a buffer model answers req and queues each byte; a serial decoder checks every frame.
module tb_entropy_uart_reader;

   localparam int CLK_DIV     = 4;
   localparam int REQ_TIMEOUT = 8;
   localparam int RESP_LAT    = 2;
`ifdef ENTROPY_UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] vector;
   logic       vector_valid;
   logic       req;
   logic       tx;
   logic       busy;
   logic       stall;

   int n_cmp;
   int n_err;

   logic [7:0] supply[$];
   logic [7:0] exp_q[$];

   entropy_uart_reader #(
      .CLK_DIV     (CLK_DIV),
      .REQ_TIMEOUT (REQ_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .vector       (vector),
      .vector_valid (vector_valid),
      .req          (req),
      .tx           (tx),
      .busy         (busy),
      .stall        (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Buffer model: answers a pending req RESP_LAT cycles later with a one-cycle valid strobe.
   initial begin : buffer_model
      int  lat_cnt;
      bit  resp_drove;
      lat_cnt      = 0;
      resp_drove   = 0;
      vector       = '0;
      vector_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_drove) begin
            vector_valid = 1'b0;
            resp_drove   = 0;
         end
         if (req === 1'b1 && supply.size() > 0 && !rst) begin
            lat_cnt++;
            if (lat_cnt >= RESP_LAT) begin
               vector       = supply.pop_front();
               vector_valid = 1'b1;
               resp_drove   = 1;
               exp_q.push_back(vector);
               lat_cnt      = 0;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   initial begin : watchdog
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog expired");
   end

   // Waits for a start bit, pops the expected byte and checks every bit cell for CLK_DIV cycles.
   task automatic receive_frame(input bit drop_en, output int req_cycles);
      logic [7:0]         exp_b;
      logic [7:0]         got;
      logic [NBITS-1:0]   exp_bits;
      logic [CLK_DIV-1:0] samp;
      bit                 found;
      bit                 busy_ok;
      bit                 req_ok;
      req_cycles = 0;
      found      = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            found = 1;
            break;
         end
         if (req === 1'b1) req_cycles++;
      end
      check("frame_start_seen", 32'(found), 32'd1);
      if (!found) return;
      if (exp_q.size() == 0) begin
         check("scoreboard_entry", 32'd0, 32'd1);
         return;
      end
      exp_b = exp_q.pop_front();
      if (drop_en) enable = 1'b0;
`ifdef ENTROPY_UART_PARITY_EN
      exp_bits = {1'b1, ^exp_b, exp_b, 1'b0};
`else
      exp_bits = {1'b1, exp_b, 1'b0};
`endif
      busy_ok = 1;
      req_ok  = 1;
      got     = '0;
      for (int b = 0; b < NBITS; b++) begin
         for (int k = 0; k < CLK_DIV; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            samp[k] = tx;
            if (busy !== 1'b1) busy_ok = 0;
            if (req !== 1'b0) req_ok = 0;
         end
         check($sformatf("frame_%02h_bit%0d", exp_b, b), 32'(samp), {32{exp_bits[b]}} & 32'((1 << CLK_DIV) - 1));
         if (b >= 1 && b <= 8) got[b-1] = samp[0];
      end
      check($sformatf("frame_%02h_data", exp_b), 32'(got), 32'(exp_b));
      check($sformatf("frame_%02h_busy", exp_b), 32'(busy_ok), 32'd1);
      check($sformatf("frame_%02h_req_low", exp_b), 32'(req_ok), 32'd0 + 32'd1);
   endtask

   initial begin : main
      int  rc;
      bit  found;
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_req", 32'(req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;

      // vector_valid in IDLE must be ignored
      @(negedge clk);
      vector_valid = 1'b1;
      vector       = 8'hEE;
      @(negedge clk);
      vector_valid = 1'b0;
      @(negedge clk);
      check("idle_valid_ignored_busy", 32'(busy), 32'd0);
      check("idle_valid_ignored_tx", 32'(tx), 32'd1);

      // Single frame 0xA5, buffer answers two cycles after req
      supply.push_back(8'hA5);
      enable = 1'b1;
      receive_frame(1, rc);
      check("a5_req_cycles", 32'(rc), 32'd2);
      @(negedge clk);
      check("a5_idle_after", 32'(busy), 32'd0);

      // Back-to-back 0x00 then 0xFF
      supply.push_back(8'h00);
      supply.push_back(8'hFF);
      enable = 1'b1;
      receive_frame(0, rc);
      @(negedge clk);
      check("b2b_req_reassert", 32'(req), 32'd1);
      receive_frame(1, rc);
      @(negedge clk);
      check("b2b_idle_after", 32'(busy), 32'd0);

      // Parity-oriented byte with odd population
      supply.push_back(8'h07);
      enable = 1'b1;
      receive_frame(1, rc);
      @(negedge clk);
      check("p07_idle_after", 32'(busy), 32'd0);

      // Request timeout sets sticky stall; a late byte clears it
      enable = 1'b1;
      found  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req === 1'b1) begin
            found = 1;
            break;
         end
      end
      check("to_req_seen", 32'(found), 32'd1);
      repeat (REQ_TIMEOUT - 1) @(negedge clk);
      check("to_stall_before", 32'(stall), 32'd0);
      @(negedge clk);
      check("to_stall_set", 32'(stall), 32'd1);
      repeat (5) @(negedge clk);
      check("to_stall_sticky", 32'(stall), 32'd1);
      check("to_req_held", 32'(req), 32'd1);
      supply.push_back(8'h3C);
      receive_frame(1, rc);
      check("to_stall_cleared", 32'(stall), 32'd0);
      @(negedge clk);
      check("to_idle_after", 32'(busy), 32'd0);

      // enable drops on the same cycle vector_valid arrives: capture wins
      enable = 1'b1;
      found  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req === 1'b1) begin
            found = 1;
            break;
         end
      end
      check("same_req_seen", 32'(found), 32'd1);
      @(negedge clk);
      vector       = 8'h5A;
      vector_valid = 1'b1;
      enable       = 1'b0;
      exp_q.push_back(8'h5A);
      @(posedge clk);
      #1 vector_valid = 1'b0;
      receive_frame(0, rc);
      @(negedge clk);
      check("same_idle_after", 32'(busy), 32'd0);
      check("same_req_low", 32'(req), 32'd0);

      // Reset pulse in the middle of DATA aborts the frame
      supply.push_back(8'hC3);
      enable = 1'b1;
      found  = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            found = 1;
            break;
         end
      end
      check("rstmid_start_seen", 32'(found), 32'd1);
      repeat (CLK_DIV + 9) @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_tx", 32'(tx), 32'd1);
      check("rstmid_req", 32'(req), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_stall", 32'(stall), 32'd0);
      exp_q.delete();
      repeat (4) @(negedge clk);
      check("rstmid_no_req", 32'(req), 32'd0);
      check("rstmid_still_idle", 32'(busy), 32'd0);
      supply.push_back(8'h96);
      enable = 1'b1;
      receive_frame(1, rc);
      @(negedge clk);
      check("rstmid_recover_idle", 32'(busy), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_entropy_uart_reader
